// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
//
// Backing-memory model for the data cache's lower-side line interface.
// Accepts one line fill (read) or writeback (write) at a time and serves it
// as a burst of WORDS_PER_LINE word beats after LATENCY cycles. Storage is
// an internal word array that reset leaves untouched.
//
// Optional feature macro: LINE_MEM_ERR_EN
//   Defined   : requests whose address lies above the array raise ERR and
//               never touch the array (reads return no beats, write beats
//               are consumed and dropped).
//   Undefined : upper address bits are ignored and ERR stays 0.
//
// Ports
//   MEM_CLK    in   clock, all state on the rising edge
//   MEM_RST_N  in   asynchronous active-low reset
//   REQ_VALID  in   request present
//   REQ_READY  out  idle and able to accept a request
//   REQ_WE     in   1 = writeback burst, 0 = line fill burst
//   REQ_ADDR   in   byte address, line offset bits ignored
//   WDATA      in   write beat data
//   WVALID     in   write beat present
//   WREADY     out  write beat accepted when WVALID is also high
//   RDATA      out  read beat data, valid with RVALID
//   RVALID     out  read beat present
//   RREADY     in   cache accepts the read beat
//   RLAST      out  final read beat of the burst
//   WDONE      out  one-cycle pulse, write burst committed
//   ERR        out  one-cycle pulse, request addressed outside the array
// ---------------------------------------------------------------------------
module line_mem_responder #(
   parameter int MEM_WORDS_LOG2 = 14,
   parameter int WORDS_PER_LINE = 8,
   parameter int LATENCY        = 4
) (
   input  logic        MEM_CLK,
   input  logic        MEM_RST_N,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] WDATA,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [31:0] RDATA,
   output logic        RVALID,
   input  logic        RREADY,
   output logic        RLAST,
   output logic        WDONE,
   output logic        ERR
);

   localparam int BEAT_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam int LAT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam int LAT_LOAD = (LATENCY >= 2) ? (LATENCY - 2) : 0;
   localparam int DEPTH    = 1 << MEM_WORDS_LOG2;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RBURST,
      S_WBURST,
      S_WRESP
   } state_t;

   state_t                    state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [LAT_W-1:0]          lat_q, lat_d;
   logic [MEM_WORDS_LOG2-1:0] base_q, base_d;
   logic                      we_q, we_d;
   logic                      err_q, err_d;

   logic [31:0]               mem [0:DEPTH-1];
   logic [MEM_WORDS_LOG2-1:0] mem_idx;
   logic                      mem_we;
   logic                      idle_ready;
   logic [MEM_WORDS_LOG2-1:0] req_base;
   logic                      req_err;
   logic                      unused_addr_bits;

   // Line base is the request's word index with the beat bits cleared, so
   // any byte address inside a line selects the whole line.
   assign req_base = {REQ_ADDR[MEM_WORDS_LOG2+1:BEAT_W+2], {BEAT_W{1'b0}}};

`ifdef LINE_MEM_ERR_EN
   assign req_err = |REQ_ADDR[31:MEM_WORDS_LOG2+2];
`else
   assign req_err = 1'b0;
`endif

   assign unused_addr_bits = ^REQ_ADDR;

   // Index wraps naturally at the array size through the narrow adder.
   assign mem_idx = base_q + MEM_WORDS_LOG2'(beat_q);

   // Where a burst starts once the latency has elapsed. A faulting read has
   // no beats at all, so it goes straight to the response pulse.
   function automatic state_t burst_entry(input logic is_write, input logic is_err);
      if (is_write) begin
         return S_WBURST;
      end else if (is_err) begin
         return S_WRESP;
      end else begin
         return S_RBURST;
      end
   endfunction

   // Next-state and output decode. The WRESP state doubles as the error
   // pulse slot for faulting reads, which is why WDONE is qualified by the
   // latched write flag there.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      lat_d      = lat_q;
      base_d     = base_q;
      we_d       = we_q;
      err_d      = err_q;
      idle_ready = 1'b0;
      RVALID     = 1'b0;
      RLAST      = 1'b0;
      WREADY     = 1'b0;
      WDONE      = 1'b0;
      ERR        = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            idle_ready = 1'b1;
            if (REQ_VALID) begin
               base_d = req_base;
               we_d   = REQ_WE;
               err_d  = req_err;
               beat_d = '0;
               lat_d  = LAT_W'(LAT_LOAD);
               if (LATENCY > 1) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = burst_entry(REQ_WE, req_err);
               end
            end
         end

         S_WAIT: begin
            if (lat_q == '0) begin
               state_d = burst_entry(we_q, err_q);
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end

         S_RBURST: begin
            RVALID = 1'b1;
            RLAST  = (beat_q == LAST_BEAT);
            if (RREADY) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = S_IDLE;
               end
            end
         end

         S_WBURST: begin
            WREADY = 1'b1;
            if (WVALID) begin
               mem_we = ~err_q;
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = S_WRESP;
               end
            end
         end

         S_WRESP: begin
            WDONE   = we_q;
            ERR     = err_q;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Ready is forced low while reset is held, not just by the reset state.
   assign REQ_READY = idle_ready & MEM_RST_N;

   // Read data is a direct view of the addressed word, so it holds steady
   // for as long as the beat is stalled.
   assign RDATA = RVALID ? mem[mem_idx] : 32'h0;

   always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
      if (!MEM_RST_N) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         lat_q   <= '0;
         base_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lat_q   <= lat_d;
         base_q  <= base_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   // The array deliberately has no reset so contents survive MEM_RST_N.
   always_ff @(posedge MEM_CLK) begin
      if (mem_we) begin
         mem[mem_idx] <= WDATA;
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_line_mem_responder
//
// Bench for line_mem_responder. A transaction-level model of the backing
// memory watches the request interface and checks every DUT output on
// every falling edge; the directed tasks add literal expectations for the
// line contents and latencies.
// ---------------------------------------------------------------------------
module tb_line_mem_responder;

   localparam int LATENCY = 4;
   localparam int DEPTH   = 16384;

   logic        MEM_CLK   = 1'b0;
   logic        MEM_RST_N = 1'b1;
   logic        REQ_VALID = 1'b0;
   logic        REQ_WE    = 1'b0;
   logic [31:0] REQ_ADDR  = 32'h0;
   logic [31:0] WDATA     = 32'h0;
   logic        WVALID    = 1'b0;
   logic        RREADY    = 1'b0;
   logic        REQ_READY;
   logic        WREADY;
   logic [31:0] RDATA;
   logic        RVALID;
   logic        RLAST;
   logic        WDONE;
   logic        ERR;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   line_mem_responder #(
      .MEM_WORDS_LOG2(14),
      .WORDS_PER_LINE(8),
      .LATENCY(LATENCY)
   ) dut (
      .MEM_CLK(MEM_CLK),
      .MEM_RST_N(MEM_RST_N),
      .REQ_VALID(REQ_VALID),
      .REQ_READY(REQ_READY),
      .REQ_WE(REQ_WE),
      .REQ_ADDR(REQ_ADDR),
      .WDATA(WDATA),
      .WVALID(WVALID),
      .WREADY(WREADY),
      .RDATA(RDATA),
      .RVALID(RVALID),
      .RREADY(RREADY),
      .RLAST(RLAST),
      .WDONE(WDONE),
      .ERR(ERR)
   );

   // Free-running clock and cycle index; a cycle is numbered by the value
   // of cyc seen at its falling edge.
   always #5 MEM_CLK = ~MEM_CLK;

   always @(posedge MEM_CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit addrErr(input logic [31:0] a);
`ifdef LINE_MEM_ERR_EN
      return |a[31:16];
`else
      return 1'b0 & (^a);
`endif
   endfunction

   // Memory model state: word array plus the one outstanding transaction.
   logic [31:0] modelMem [0:DEPTH-1];
   bit          busy    = 1'b0;
   bit          curWe   = 1'b0;
   bit          curErr  = 1'b0;
   logic [13:0] curBase = '0;
   int          startCyc = 0;
   int          wBeats   = 0;
   logic [31:0] expQ [$];

   // Per-cycle compare against the model. While busy, nothing may appear
   // before the latency has elapsed; afterwards reads drain the expected
   // line in order, writes take 8 beats then a single WDONE.
   always @(negedge MEM_CLK) begin
      logic [13:0] idx;
      if (!MEM_RST_N) begin
         checkOutput("rst_req_ready", 32'(REQ_READY), 0);
         checkOutput("rst_rvalid", 32'(RVALID), 0);
         checkOutput("rst_rlast", 32'(RLAST), 0);
         checkOutput("rst_wready", 32'(WREADY), 0);
         checkOutput("rst_wdone", 32'(WDONE), 0);
         checkOutput("rst_err", 32'(ERR), 0);
         checkOutput("rst_rdata", RDATA, 0);
         busy = 1'b0;
         wBeats = 0;
         expQ.delete();
      end else if (!busy) begin
         checkOutput("idle_req_ready", 32'(REQ_READY), 1);
         checkOutput("idle_rvalid", 32'(RVALID), 0);
         checkOutput("idle_wready", 32'(WREADY), 0);
         checkOutput("idle_wdone", 32'(WDONE), 0);
         checkOutput("idle_err", 32'(ERR), 0);
         if (REQ_VALID) begin
            busy     = 1'b1;
            startCyc = cyc + LATENCY;
            curWe    = REQ_WE;
            curErr   = addrErr(REQ_ADDR);
            curBase  = {REQ_ADDR[15:5], 3'b000};
            wBeats   = 0;
            expQ.delete();
            if (!REQ_WE && !curErr) begin
               for (int i = 0; i < 8; i++) begin
                  idx = curBase + 14'(i);
                  expQ.push_back(modelMem[idx]);
               end
            end
         end
      end else begin
         checkOutput("busy_req_ready", 32'(REQ_READY), 0);
         if (cyc < startCyc) begin
            checkOutput("lat_rvalid", 32'(RVALID), 0);
            checkOutput("lat_wready", 32'(WREADY), 0);
            checkOutput("lat_wdone", 32'(WDONE), 0);
            checkOutput("lat_err", 32'(ERR), 0);
         end else if (!curWe && curErr) begin
            checkOutput("rerr_err", 32'(ERR), 1);
            checkOutput("rerr_rvalid", 32'(RVALID), 0);
            checkOutput("rerr_wdone", 32'(WDONE), 0);
            busy = 1'b0;
         end else if (!curWe) begin
            checkOutput("rd_rvalid", 32'(RVALID), 1);
            checkOutput("rd_wready", 32'(WREADY), 0);
            checkOutput("rd_wdone", 32'(WDONE), 0);
            checkOutput("rd_err", 32'(ERR), 0);
            if (expQ.size() > 0) begin
               checkOutput("rd_rdata", RDATA, expQ[0]);
               checkOutput("rd_rlast", 32'(RLAST), 32'(expQ.size() == 1));
               if (RREADY && RVALID) begin
                  void'(expQ.pop_front());
                  if (expQ.size() == 0) busy = 1'b0;
               end
            end
         end else if (wBeats < 8) begin
            checkOutput("wr_wready", 32'(WREADY), 1);
            checkOutput("wr_rvalid", 32'(RVALID), 0);
            checkOutput("wr_wdone", 32'(WDONE), 0);
            checkOutput("wr_err", 32'(ERR), 0);
            if (WVALID && WREADY) begin
               if (!curErr) begin
                  idx = curBase + 14'(wBeats);
                  modelMem[idx] = WDATA;
               end
               wBeats++;
            end
         end else begin
            checkOutput("wresp_wdone", 32'(WDONE), 1);
            checkOutput("wresp_err", 32'(ERR), 32'(curErr));
            checkOutput("wresp_wready", 32'(WREADY), 0);
            busy = 1'b0;
         end
      end
   end

   // Presents a request and returns the cycle in which it was accepted.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, output int accCyc);
      int n = 0;
      REQ_WE    = we;
      REQ_ADDR  = addr;
      REQ_VALID = 1'b1;
      accCyc    = -1;
      while (accCyc < 0 && n < 50) begin
         @(negedge MEM_CLK);
         if (REQ_READY) accCyc = cyc;
         n++;
         @(posedge MEM_CLK);
         #1;
      end
      REQ_VALID = 1'b0;
      if (accCyc < 0) checkOutput("accept_timeout", 0, 1);
   endtask

   // Write burst of words first + step*i; optionally WVALID every other cycle.
   task automatic writeBurst(input logic [31:0] addr, input logic [31:0] first,
                             input logic [31:0] step, input bit gaps);
      int acc, beat, it, n, firstCyc, lastCyc, doneCyc;
      applyStimulus(1'b1, addr, acc);
      beat = 0; it = 0; firstCyc = -1; lastCyc = -1; doneCyc = -1;
      while (beat < 8 && it < 100) begin
         WVALID = gaps ? (it % 2 == 1) : 1'b1;
         WDATA  = first + step * beat;
         @(negedge MEM_CLK);
         if (WVALID && WREADY) begin
            if (beat == 0) firstCyc = cyc;
            lastCyc = cyc;
            beat++;
         end
         it++;
         @(posedge MEM_CLK);
         #1;
      end
      WVALID = 1'b0;
      checkOutput("w_beats", beat, 8);
      checkOutput("w_first_latency", firstCyc - acc, 4);
      n = 0;
      while (doneCyc < 0 && n < 20) begin
         @(negedge MEM_CLK);
         if (WDONE) doneCyc = cyc;
         n++;
         @(posedge MEM_CLK);
         #1;
      end
      checkOutput("w_done_cycle", doneCyc - lastCyc, 1);
   endtask

   // Read burst expecting first + step*i; RREADY held low for stallLen
   // cycles on beats stallLo..stallHi. abortBeat >= 0 asserts reset while
   // that beat is presented.
   task automatic readBurst(input logic [31:0] addr, input logic [31:0] first,
                            input logic [31:0] step, input int stallLo, input int stallHi,
                            input int stallLen, input int abortBeat);
      int acc, beat, it, firstCyc, stallLeft;
      bit aborted;
      logic [31:0] got [8];
      logic        gotLast [8];
      applyStimulus(1'b0, addr, acc);
      beat = 0; it = 0; firstCyc = -1; aborted = 1'b0;
      stallLeft = (stallLo <= 0 && 0 <= stallHi) ? stallLen : 0;
      while (beat < 8 && it < 100 && !aborted) begin
         RREADY = (stallLeft == 0) && (beat != abortBeat);
         @(negedge MEM_CLK);
         if (RVALID) begin
            if (firstCyc < 0) firstCyc = cyc;
            if (beat == abortBeat) begin
               #2 MEM_RST_N = 1'b0;
               #1 checkOutput("rst_drops_rvalid", 32'(RVALID), 0);
               aborted = 1'b1;
            end else if (RREADY) begin
               got[beat]     = RDATA;
               gotLast[beat] = RLAST;
               beat++;
               stallLeft = (stallLo <= beat && beat <= stallHi) ? stallLen : 0;
            end else begin
               checkOutput("stall_rdata", RDATA, first + step * beat);
               stallLeft--;
            end
         end
         it++;
         if (!aborted) begin
            @(posedge MEM_CLK);
            #1;
         end
      end
      RREADY = 1'b0;
      checkOutput("r_first_latency", firstCyc - acc, 4);
      if (aborted) begin
         checkOutput("r_beats_before_rst", beat, abortBeat);
      end else begin
         checkOutput("r_beats", beat, 8);
         for (int i = 0; i < 8; i++) begin
            checkOutput("r_word", got[i], first + step * i);
            checkOutput("r_last_flag", 32'(gotLast[i]), 32'(i == 7));
         end
      end
   endtask

`ifdef LINE_MEM_ERR_EN
   task automatic errRead(input logic [31:0] addr);
      int acc, n, errCyc;
      bit sawRvalid;
      applyStimulus(1'b0, addr, acc);
      n = 0; errCyc = -1; sawRvalid = 1'b0;
      while (errCyc < 0 && n < 20) begin
         @(negedge MEM_CLK);
         if (RVALID) sawRvalid = 1'b1;
         if (ERR) errCyc = cyc;
         n++;
         @(posedge MEM_CLK);
         #1;
      end
      checkOutput("err_latency", errCyc - acc, 4);
      checkOutput("err_no_rvalid", 32'(sawRvalid), 0);
      @(negedge MEM_CLK);
      checkOutput("err_back_idle", 32'(REQ_READY), 1);
      @(posedge MEM_CLK);
      #1;
   endtask
`endif

   initial begin
      #1 MEM_RST_N = 1'b0;
      repeat (3) @(posedge MEM_CLK);
      #1 MEM_RST_N = 1'b1;
      $display("[TB] reset released");

      // Plain write then read of line 0x120.
      writeBurst(32'h0000_0120, 32'h1111_1111, 32'h1111_1111, 1'b0);
      readBurst(32'h0000_0120, 32'h1111_1111, 32'h1111_1111, -1, -2, 0, -1);

      // Back-pressure on beats 3..5 (indices 2..4).
      readBurst(32'h0000_0120, 32'h1111_1111, 32'h1111_1111, 2, 4, 2, -1);

      // Gapped write to another line, then readback.
      writeBurst(32'h0000_0200, 32'hC0DE_0000, 32'h0000_0001, 1'b1);
      readBurst(32'h0000_0200, 32'hC0DE_0000, 32'h0000_0001, -1, -2, 0, -1);

      // Unaligned address selects the containing line.
      readBurst(32'h0000_013C, 32'h1111_1111, 32'h1111_1111, -1, -2, 0, -1);

      // Reset in the middle of a read; array contents must survive.
      readBurst(32'h0000_0120, 32'h1111_1111, 32'h1111_1111, -1, -2, 0, 3);
      repeat (2) @(posedge MEM_CLK);
      #1 MEM_RST_N = 1'b1;
      @(negedge MEM_CLK);
      checkOutput("ready_after_rst", 32'(REQ_READY), 1);
      @(posedge MEM_CLK);
      #1;
      readBurst(32'h0000_0120, 32'h1111_1111, 32'h1111_1111, -1, -2, 0, -1);

      // Address above the array.
      writeBurst(32'h0000_0000, 32'hA000_0000, 32'h0000_0001, 1'b0);
`ifdef LINE_MEM_ERR_EN
      errRead(32'h0001_0000);
`else
      readBurst(32'h0001_0000, 32'hA000_0000, 32'h0000_0001, -1, -2, 0, -1);
`endif

      repeat (3) @(posedge MEM_CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
Backing-memory responder for the data cache's lower-side line interface. It accepts one line-fill (read) or writeback (write) request at a time and serves it as a burst of word beats after a fixed access latency. It replaces the ideal main memory in simulation and gives the cache's miss and writeback FSMs a realistic, stallable partner. Storage is an internal word array; contents are not cleared by reset.

Parameters:
MEM_WORDS_LOG2, 14, log2 of array depth in 32-bit words (default covers byte addresses 0x0000–0xFFFF)
WORDS_PER_LINE, 8, beats per burst; power of two; matches the 32-byte cache line
LATENCY, 4, cycles from request-accept edge to first beat (read) or first WREADY (write); must be >=1

Ports:
MEM_CLK  in  1  clock, all state on rising edge
MEM_RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  responder idle and able to accept a request
REQ_WE  in  1  1 = writeback (write burst), 0 = line fill (read burst)
REQ_ADDR  in  32  byte address; low log2(WORDS_PER_LINE)+2 bits ignored (line-aligned)
WDATA  in  32  write beat data
WVALID  in  1  write beat present
WREADY  out  1  responder accepts write beat
RDATA  out  32  read beat data, valid when RVALID=1
RVALID  out  1  read beat present
RREADY  in  1  cache accepts read beat
RLAST  out  1  marks final read beat
WDONE  out  1  one-cycle pulse: write burst committed
ERR  out  1  one-cycle pulse: request error (see Optional Feature)

Behaviour:
- States: IDLE, WAIT, RBURST, WBURST, WRESP.
- Reset (MEM_RST_N=0, async): state IDLE, beat and latency counters 0. RVALID, RLAST, WREADY, WDONE, ERR are 0; RDATA is 0; REQ_READY is 0 while reset is asserted. The array is not reset.
- IDLE: REQ_READY=1. A request is accepted on a rising edge with REQ_VALID&REQ_READY. On accept, latch the line base (REQ_ADDR word index with beat bits cleared) and REQ_WE, load the latency counter, and go to WAIT.
- WAIT: counts LATENCY-1 cycles, then goes to RBURST or WBURST. The first RVALID/WREADY is high in cycle N+LATENCY, where N is the accept cycle.
- RBURST: RVALID=1. RDATA = mem[base+beat] and is stable while RVALID&~RREADY. Beat advances on RVALID&RREADY. RLAST=1 when beat==WORDS_PER_LINE-1. The last handshake returns to IDLE, so REQ_READY=1 on the next cycle.
- WBURST: WREADY=1. On WVALID&WREADY, write mem[base+beat]=WDATA and advance the beat. WVALID gaps are tolerated indefinitely. After the last beat, go to WRESP.
- WRESP: WDONE=1 for exactly one cycle, then IDLE. All writes are visible to any request accepted afterward.
- Beat counter is log2(WORDS_PER_LINE) bits, always starts at 0, and wraps to 0 at the end of each burst.
- Array index = (line base + beat) modulo 2^MEM_WORDS_LOG2.
- REQ_VALID held during a burst is ignored until IDLE. WVALID during RBURST and RREADY during WBURST are ignored.

Optional Feature:
LINE_MEM_ERR_EN
- Defined: a request with any of REQ_ADDR[31:MEM_WORDS_LOG2+2] nonzero is accepted normally and goes through WAIT, but never touches the array.
  - Read: no RVALID beats; ERR pulses in cycle N+LATENCY, then IDLE.
  - Write: all WORDS_PER_LINE beats are consumed via WREADY and discarded; WDONE and ERR pulse together, then IDLE.
- Undefined: upper address bits are ignored (address wraps modulo array size) and ERR is tied to 0.

Test Plan:
1. Write burst to line 0x0000_0120 with words 0x11111111..0x88888888, then a read burst of the same line.
   - Write: WREADY first high 4 cycles after accept; WDONE pulses once after the 8th beat.
   - Read: first RVALID exactly 4 cycles after accept; beats arrive in order with RLAST only on the 8th.
2. Read 0x0000_0120 with RREADY low for beats 3–5: RDATA/RVALID hold 0x33333333 stable, and all 8 beats are delivered exactly once.
3. Write with WVALID low every other cycle: exactly 8 words are stored, verified by readback; WDONE is not early.
4. Read request at 0x0000_013C: returns the same 8 words as line 0x0000_0120 (low bits ignored).
5. Assert MEM_RST_N=0 during beat 4 of a read:
   - RVALID drops immediately.
   - After release, REQ_READY=1 and a new read of 0x120 returns the data from test 1 (array preserved).
6. Read 0x0001_0000:
   - With LINE_MEM_ERR_EN: ERR pulses 4 cycles after accept and no RVALID occurs.
   - Without it: the line at 0x0000_0000 is returned.
